fft_frame_sequencer: RTL and testbench

- Controller that sequences one FFT frame at a time through the pitch-detect datapath: input buffer → R2²SDF FFT → magnitude-squared → peak finder.
- Accepts a frame-complete pulse from the input buffer, strobes NSamples samples into the FFT, and counts the NSamples output bins, flagging only the positive-frequency half.
- Latches the peak bin into a held valid/ready result, keeps one pending frame, counts dropped frames, and times out a stalled FFT.
- Entirely in the FFT clock domain.

---
 rtl/fft_frame_sequencer_if.sv | 40 ++++
 rtl/fft_frame_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_fft_frame_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/fft_frame_sequencer_if.sv
// fft_frame_sequencer_if: handshake/bus bundle between the FFT frame sequencer
// and the surrounding pitch-detect datapath (input buffer, FFT, peak finder).
//   frame_ready/frame_ack          : input buffer frame handshake
//   feed_en/feed_idx               : FFT di_en and buffer read index
//   fft_do_en/bin_idx/bin_valid    : FFT output bin tracking
//   peak_valid/peak_k              : peak-finder result
//   result_valid/result_ready/data : held pitch result towards the consumer
//   busy/dropped/timeout_err       : status
// Modport master is the sequencer side; modport slave is the environment side.
interface fft_frame_sequencer_if #(
  parameter int unsigned KW = 10
);
  logic          frame_ready;
  logic          frame_ack;
  logic          feed_en;
  logic [KW-1:0] feed_idx;
  logic          fft_do_en;
  logic [KW-1:0] bin_idx;
  logic          bin_valid;
  logic          peak_valid;
  logic [KW-1:0] peak_k;
  logic          result_valid;
  logic          result_ready;
  logic [KW-1:0] result_data;
  logic          busy;
  logic [7:0]    dropped;
  logic          timeout_err;

  modport master (
    input  frame_ready, fft_do_en, peak_valid, peak_k, result_ready,
    output frame_ack, feed_en, feed_idx, bin_idx, bin_valid,
           result_valid, result_data, busy, dropped, timeout_err
  );

  modport slave (
    output frame_ready, fft_do_en, peak_valid, peak_k, result_ready,
    input  frame_ack, feed_en, feed_idx, bin_idx, bin_valid,
           result_valid, result_data, busy, dropped, timeout_err
  );
endinterface

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: sequences one FFT frame at a time through
// input buffer -> FFT -> magnitude-squared -> peak finder, in the FFT clock domain.
// Ports:
//   clk   : FFT clock
//   reset : synchronous, active-high
//   bus   : fft_frame_sequencer_if.master (frame handshake, feed strobe/index,
//           output bin tracking, peak input, held result, status)
// Optional feature macro: FFT_SEQ_HOLDOFF_EN adds a HOLD gap of HOLDOFF cycles
// after each result handshake.
module fft_frame_sequencer #(
  parameter int unsigned NSamples = 1024,
  parameter int unsigned KW       = 10,
  parameter int unsigned TIMEOUT  = 4096,
  parameter int unsigned HOLDOFF  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  fft_frame_sequencer_if.master   bus
);

  localparam int unsigned   TW       = $clog2(TIMEOUT + 1);
  localparam logic [KW-1:0] LAST_IDX = KW'(NSamples - 1);
  localparam logic [KW-1:0] HALF_IDX = KW'(NSamples / 2);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
`ifdef FFT_SEQ_HOLDOFF_EN
  localparam int unsigned   HW        = $clog2(HOLDOFF + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF - 1);
`endif

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FEED      = 3'd1;
  localparam logic [2:0] S_WAIT_OUT  = 3'd2;
  localparam logic [2:0] S_COLLECT   = 3'd3;
  localparam logic [2:0] S_WAIT_PEAK = 3'd4;
  localparam logic [2:0] S_REPORT    = 3'd5;
`ifdef FFT_SEQ_HOLDOFF_EN
  localparam logic [2:0] S_HOLD      = 3'd6;
`endif

  // Elaboration-time parameter sanity check
  if (KW != $clog2(NSamples) || NSamples < 8 || TIMEOUT == 0 || HOLDOFF == 0) begin : g_param_err
    $error("fft_frame_sequencer: illegal parameter set");
  end

  logic [2:0]    state_q, state_d;
  logic          pending_q, pending_d;
  logic          frame_ack_q, frame_ack_d;
  logic          feed_en_q, feed_en_d;
  logic [KW-1:0] feed_idx_q, feed_idx_d;
  logic [KW-1:0] bin_idx_q, bin_idx_d;
  logic          result_valid_q, result_valid_d;
  logic [KW-1:0] result_data_q, result_data_d;
  logic          busy_q, busy_d;
  logic [7:0]    dropped_q, dropped_d;
  logic          timeout_err_q, timeout_err_d;
  logic [TW-1:0] tmo_q, tmo_d;
`ifdef FFT_SEQ_HOLDOFF_EN
  logic [HW-1:0] hold_q, hold_d;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d        = state_q;
    pending_d      = pending_q;
    frame_ack_d    = 1'b0;
    feed_en_d      = feed_en_q;
    feed_idx_d     = feed_idx_q;
    bin_idx_d      = bin_idx_q;
    result_valid_d = result_valid_q;
    result_data_d  = result_data_q;
    dropped_d      = dropped_q;
    timeout_err_d  = timeout_err_q;
    tmo_d          = tmo_q;
`ifdef FFT_SEQ_HOLDOFF_EN
    hold_d         = hold_q;
`endif

    // A frame arriving while busy is parked; a second one while parked is lost
    if (bus.frame_ready && state_q != S_IDLE) begin
      if (pending_q) begin
        if (dropped_q != 8'hFF) dropped_d = dropped_q + 8'd1;
      end else begin
        pending_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.frame_ready || pending_q) begin
          state_d     = S_FEED;
          frame_ack_d = 1'b1;
          feed_en_d   = 1'b1;
          feed_idx_d  = '0;
          // A fresh pulse coinciding with a parked start stays parked
          pending_d   = pending_q && bus.frame_ready;
        end
      end
      S_FEED: begin
        if (feed_idx_q == LAST_IDX) begin
          state_d    = S_WAIT_OUT;
          feed_en_d  = 1'b0;
          feed_idx_d = '0;
          tmo_d      = '0;
        end else begin
          feed_idx_d = feed_idx_q + KW'(1);
        end
      end
      S_WAIT_OUT: begin
        // First do_en is bin 0, already presented by bin_idx_q
        if (bus.fft_do_en) begin
          state_d   = S_COLLECT;
          bin_idx_d = bin_idx_q + KW'(1);
        end else if (tmo_q == TMO_LAST) begin
          state_d       = S_IDLE;
          timeout_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_COLLECT: begin
        if (bus.fft_do_en) begin
          if (bin_idx_q == LAST_IDX) begin
            state_d   = S_WAIT_PEAK;
            bin_idx_d = '0;
            tmo_d     = '0;
          end else begin
            bin_idx_d = bin_idx_q + KW'(1);
          end
        end
      end
      S_WAIT_PEAK: begin
        if (bus.peak_valid) begin
          state_d        = S_REPORT;
          result_valid_d = 1'b1;
          result_data_d  = bus.peak_k;
        end else if (tmo_q == TMO_LAST) begin
          state_d       = S_IDLE;
          timeout_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_REPORT: begin
        if (bus.result_ready) begin
          result_valid_d = 1'b0;
`ifdef FFT_SEQ_HOLDOFF_EN
          state_d        = S_HOLD;
          hold_d         = '0;
`else
          state_d        = S_IDLE;
`endif
        end
      end
`ifdef FFT_SEQ_HOLDOFF_EN
      S_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = S_IDLE;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      pending_q      <= 1'b0;
      frame_ack_q    <= 1'b0;
      feed_en_q      <= 1'b0;
      feed_idx_q     <= '0;
      bin_idx_q      <= '0;
      result_valid_q <= 1'b0;
      result_data_q  <= '0;
      busy_q         <= 1'b0;
      dropped_q      <= '0;
      timeout_err_q  <= 1'b0;
      tmo_q          <= '0;
`ifdef FFT_SEQ_HOLDOFF_EN
      hold_q         <= '0;
`endif
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      frame_ack_q    <= frame_ack_d;
      feed_en_q      <= feed_en_d;
      feed_idx_q     <= feed_idx_d;
      bin_idx_q      <= bin_idx_d;
      result_valid_q <= result_valid_d;
      result_data_q  <= result_data_d;
      busy_q         <= busy_d;
      dropped_q      <= dropped_d;
      timeout_err_q  <= timeout_err_d;
      tmo_q          <= tmo_d;
`ifdef FFT_SEQ_HOLDOFF_EN
      hold_q         <= hold_d;
`endif
    end
  end

  assign bus.frame_ack    = frame_ack_q;
  assign bus.feed_en      = feed_en_q;
  assign bus.feed_idx     = feed_idx_q;
  assign bus.bin_idx      = bin_idx_q;
  // Only the positive-frequency half of the spectrum is flagged
  assign bus.bin_valid    = bus.fft_do_en && (bin_idx_q < HALF_IDX);
  assign bus.result_valid = result_valid_q;
  assign bus.result_data  = result_data_q;
  assign bus.busy         = busy_q;
  assign bus.dropped      = dropped_q;
  assign bus.timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer: table-driven frame runs with a result scoreboard,
// plus hand-written timeout and mid-frame reset sequences.
module tb_fft_frame_sequencer;
  localparam int unsigned N  = 16;
  localparam int unsigned KW = 4;
  localparam int unsigned TO = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fft_frame_sequencer_if #(.KW(KW)) bus ();

  fft_frame_sequencer #(.NSamples(N), .KW(KW), .TIMEOUT(TO), .HOLDOFF(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit start;        // 1: pulse frame_ready; 0: frame expected from pending
    int extra;        // frame_ready pulses injected during FEED
    int pre;          // WAIT_OUT cycles before first do_en (>=1)
    int gap;          // idle cycles between do_en strobes
    int k;            // peak bin reported by the peak finder
    int rdy;          // cycles result_ready is held low
    int exp_dropped;  // dropped count after the frame
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input vec_t v);
    int ack_cnt;
    int pulses;
    int got;
    ack_cnt = 0;
    pulses  = 0;
    if (v.start) bus.frame_ready = 1'b1;
    tick();
    bus.frame_ready = 1'b0;
    check("first_ack", int'(bus.frame_ack), 1);
    for (int i = 0; i < int'(N); i++) begin
      check("feed_en", int'(bus.feed_en), 1);
      check("feed_idx", int'(bus.feed_idx), i);
      ack_cnt += int'(bus.frame_ack);
      if (pulses < v.extra && (i % 2) == 1) begin
        bus.frame_ready = 1'b1;
        pulses++;
      end
      tick();
      bus.frame_ready = 1'b0;
    end
    check("ack_cycles", ack_cnt, 1);
    check("feed_done", int'(bus.feed_en), 0);
    check("busy_wait", int'(bus.busy), 1);
    for (int c = 0; c < v.pre; c++) begin
      if (c == 0) begin
        bus.peak_valid = 1'b1;  // must be ignored outside WAIT_PEAK
        bus.peak_k     = KW'(v.k ^ 5);
      end
      tick();
      bus.peak_valid = 1'b0;
    end
    for (int b = 0; b < int'(N); b++) begin
      bus.fft_do_en = 1'b1;
      #1;
      check("bin_idx", int'(bus.bin_idx), b);
      check("bin_valid", int'(bus.bin_valid), (b < int'(N / 2)) ? 1 : 0);
      tick();
      bus.fft_do_en = 1'b0;
      for (int g = 0; g < v.gap; g++) tick();
    end
    check("bin_wrap", int'(bus.bin_idx), 0);
    check("no_early_result", int'(bus.result_valid), 0);
    bus.peak_valid = 1'b1;
    bus.peak_k     = KW'(v.k);
    exp_q.push_back(v.k);
    tick();
    bus.peak_valid = 1'b0;
    for (int r = 0; r < v.rdy; r++) begin
      check("result_valid_hold", int'(bus.result_valid), 1);
      check("result_data_hold", int'(bus.result_data), exp_q[0]);
      tick();
    end
    bus.result_ready = 1'b1;
    #1;
    check("result_valid", int'(bus.result_valid), 1);
    if (bus.result_valid && exp_q.size() > 0) begin
      got = exp_q.pop_front();
      check("result_data", int'(bus.result_data), got);
    end
    tick();
    bus.result_ready = 1'b0;
    check("result_clear", int'(bus.result_valid), 0);
    check("busy_drop", int'(bus.busy), 0);
    check("dropped", int'(bus.dropped), v.exp_dropped);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int rv;
    int ack_cnt;
    vecs[0] = '{start: 1, extra: 0, pre: 40, gap: 0, k: 3,  rdy: 0,  exp_dropped: 0};
    vecs[1] = '{start: 1, extra: 0, pre: 2,  gap: 1, k: 3,  rdy: 20, exp_dropped: 0};
    vecs[2] = '{start: 1, extra: 3, pre: 5,  gap: 0, k: 7,  rdy: 0,  exp_dropped: 2};
    vecs[3] = '{start: 0, extra: 0, pre: 1,  gap: 2, k: 12, rdy: 3,  exp_dropped: 2};
    vecs[4] = '{start: 1, extra: 0, pre: 62, gap: 0, k: 15, rdy: 1,  exp_dropped: 2};

    reset            = 1'b1;
    bus.frame_ready  = 1'b0;
    bus.fft_do_en    = 1'b0;
    bus.peak_valid   = 1'b0;
    bus.peak_k       = '0;
    bus.result_ready = 1'b0;
    repeat (3) tick();
    check("rst_frame_ack", int'(bus.frame_ack), 0);
    check("rst_feed_en", int'(bus.feed_en), 0);
    check("rst_feed_idx", int'(bus.feed_idx), 0);
    check("rst_bin_idx", int'(bus.bin_idx), 0);
    check("rst_result_valid", int'(bus.result_valid), 0);
    check("rst_result_data", int'(bus.result_data), 0);
    check("rst_dropped", int'(bus.dropped), 0);
    check("rst_timeout_err", int'(bus.timeout_err), 0);
    check("rst_busy", int'(bus.busy), 0);
    reset = 1'b0;
    tick();

    for (int v = 0; v < 5; v++) run_frame(vecs[v]);

    // Stalled FFT: no do_en after the feed
    bus.frame_ready = 1'b1;
    tick();
    bus.frame_ready = 1'b0;
    repeat (N) tick();
    rv = 0;
    repeat (TO - 1) begin
      rv += int'(bus.result_valid);
      tick();
    end
    check("tmo_busy_before", int'(bus.busy), 1);
    check("tmo_err_before", int'(bus.timeout_err), 0);
    tick();
    check("tmo_busy_after", int'(bus.busy), 0);
    check("tmo_err_after", int'(bus.timeout_err), 1);
    check("tmo_no_result", rv + int'(bus.result_valid), 0);
    tick();
    check("tmo_err_sticky", int'(bus.timeout_err), 1);

    // Reset in the middle of COLLECT at bin 5, with a frame parked
    bus.frame_ready = 1'b1;
    tick();
    bus.frame_ready = 1'b0;
    repeat (N) tick();
    repeat (5) begin
      bus.fft_do_en = 1'b1;
      tick();
      bus.fft_do_en = 1'b0;
    end
    check("mid_bin_idx", int'(bus.bin_idx), 5);
    bus.frame_ready = 1'b1;
    tick();
    bus.frame_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mr_bin_idx", int'(bus.bin_idx), 0);
    check("mr_busy", int'(bus.busy), 0);
    check("mr_result_data", int'(bus.result_data), 0);
    check("mr_dropped", int'(bus.dropped), 0);
    check("mr_timeout_err", int'(bus.timeout_err), 0);
    check("mr_feed_en", int'(bus.feed_en), 0);
    ack_cnt = 0;
    repeat (3) begin
      tick();
      ack_cnt += int'(bus.frame_ack) + int'(bus.busy);
    end
    check("mr_pending_cleared", ack_cnt, 0);
    run_frame('{start: 1, extra: 0, pre: 3, gap: 0, k: 9, rdy: 2, exp_dropped: 0});

    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
